// File: rtl/mygo_chan_pkg.sv
// mygo_chan_pkg: shared types, constants and helpers for the Go channel blocks
package mygo_chan_pkg;

    localparam logic RST_ASSERTED = 1'b0;

    typedef struct packed {
        logic valid;
        logic ready;
    } chan_hs_t;

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } chan_state_e;

    function automatic int chan_idw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mygo_rr_pick.sv
// mygo_rr_pick: combinational round-robin pick of the first valid requester at or after ptr
module mygo_rr_pick import mygo_chan_pkg::*; #(
    parameter int N   = 4,
    parameter int IDW = chan_idw(N)
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    assign any = |valid;

    // scan from farthest to nearest so the requester closest to ptr overwrites and wins
    always_comb begin
        int i;
        i = 0;
        grant = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            i = int'(ptr) + k;
            i = (i >= N) ? i - N : i;
            if (valid[i]) begin
                grant = '0;
                grant[i] = 1'b1;
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/mygo_chan_arb.sv
// mygo_chan_arb: round-robin fan-in of N senders onto one channel FIFO write port
module mygo_chan_arb import mygo_chan_pkg::*; #(
    parameter int N_SENDERS = 4,
    parameter int WIDTH     = 32,
    parameter int IDW       = chan_idw(N_SENDERS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SENDERS*WIDTH-1:0] s_wdata,
    input  logic [N_SENDERS-1:0]       s_wvalid,
    output logic [N_SENDERS-1:0]       s_wready,
    output logic [WIDTH-1:0]           chan_wdata,
    output logic                       chan_wvalid,
    input  logic                       chan_wready,
    output logic [IDW-1:0]             grant_id,
    output logic                       busy
);

    chan_state_e          state_q;
    chan_hs_t             out_hs;
    logic [WIDTH-1:0]     data_q;
    logic [IDW-1:0]       grant_q;
    logic [IDW-1:0]       ptr_q;
    logic [IDW-1:0]       ptr_next;
    logic [IDW-1:0]       pick_idx;
    logic [N_SENDERS-1:0] pick_oh;
    logic                 pick_any;
    logic                 can_load;
    logic                 accept;
    logic [WIDTH-1:0]     words [N_SENDERS];

    genvar g;
    for (g = 0; g < N_SENDERS; g++) begin : g_word
        assign words[g] = s_wdata[g*WIDTH +: WIDTH];
    end

    mygo_rr_pick #(.N(N_SENDERS), .IDW(IDW)) u_pick (
        .valid (s_wvalid),
        .ptr   (ptr_q),
        .grant (pick_oh),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign out_hs   = '{valid: state_q == ST_FULL, ready: chan_wready};
    assign can_load = !out_hs.valid | out_hs.ready;
    // no sender is told it was taken while reset holds the register empty
    assign accept   = (rst != RST_ASSERTED) & can_load & pick_any;
    assign s_wready = accept ? pick_oh : '0;
    // explicit wrap so non-power-of-two sender counts stay in range
    assign ptr_next = (int'(pick_idx) == N_SENDERS - 1) ? '0 : pick_idx + IDW'(1);

    assign chan_wvalid = out_hs.valid;
    assign busy        = out_hs.valid;
    assign chan_wdata  = data_q;
    assign grant_id    = grant_q;

    // output register: load on accept (even while draining), otherwise empty on drain
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ASSERTED) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            grant_q <= '0;
            ptr_q   <= '0;
        end else if (accept) begin
            state_q <= ST_FULL;
            data_q  <= words[pick_idx];
            grant_q <= pick_idx;
            ptr_q   <= ptr_next;
        end else if (chan_wready) begin
            state_q <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_mygo_chan_arb.sv
// tb_mygo_chan_arb: directed vector table plus hand sequences for reset corners
module tb_mygo_chan_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] s_wdata = '0;
    logic [3:0]   s_wvalid = '0;
    logic [3:0]   s_wready;
    logic [31:0]  chan_wdata;
    logic         chan_wvalid;
    logic         chan_wready = 1'b0;
    logic [1:0]   grant_id;
    logic         busy;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mygo_chan_arb #(.N_SENDERS(4), .WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_wdata     (s_wdata),
        .s_wvalid    (s_wvalid),
        .s_wready    (s_wready),
        .chan_wdata  (chan_wdata),
        .chan_wvalid (chan_wvalid),
        .chan_wready (chan_wready),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    typedef struct {
        logic [3:0]   v;
        logic         r;
        logic [127:0] d;
        logic [3:0]   sr;
        logic         ev;
        logic [31:0]  ed;
        logic [1:0]   eg;
    } vec_t;

    localparam logic [127:0] D0 = {32'h13, 32'h12, 32'h11, 32'h10};
    localparam logic [127:0] DA = {32'h13, 32'hAB, 32'h11, 32'h10};
    localparam logic [127:0] DC = {32'h13, 32'hCD, 32'h11, 32'h10};

    vec_t vec [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic r, input logic [127:0] d,
                                input logic [3:0] sr, input logic ev, input logic [31:0] ed,
                                input logic [1:0] eg);
        vec_t x;
        x.v = v; x.r = r; x.d = d; x.sr = sr; x.ev = ev; x.ed = ed; x.eg = eg;
        return x;
    endfunction

    task automatic check_regs(input string tag, input logic ev, input logic [31:0] ed, input logic [1:0] eg);
        check({tag, " chan_wvalid"}, 64'(chan_wvalid), 64'(ev));
        check({tag, " busy"}, 64'(busy), 64'(ev));
        check({tag, " chan_wdata"}, 64'(chan_wdata), 64'(ed));
        check({tag, " grant_id"}, 64'(grant_id), 64'(eg));
    endtask

    initial begin
        vec[0]  = mk(4'hF, 1'b1, D0, 4'b0001, 1'b1, 32'h10, 2'd0);
        vec[1]  = mk(4'hF, 1'b1, D0, 4'b0010, 1'b1, 32'h11, 2'd1);
        vec[2]  = mk(4'hF, 1'b1, D0, 4'b0100, 1'b1, 32'h12, 2'd2);
        vec[3]  = mk(4'hF, 1'b1, D0, 4'b1000, 1'b1, 32'h13, 2'd3);
        vec[4]  = mk(4'hF, 1'b1, D0, 4'b0001, 1'b1, 32'h10, 2'd0);
        vec[5]  = mk(4'h0, 1'b1, D0, 4'b0000, 1'b0, 32'h10, 2'd0);
        vec[6]  = mk(4'h4, 1'b0, DA, 4'b0100, 1'b1, 32'hAB, 2'd2);
        vec[7]  = mk(4'h4, 1'b0, DA, 4'b0000, 1'b1, 32'hAB, 2'd2);
        vec[8]  = mk(4'h4, 1'b0, DA, 4'b0000, 1'b1, 32'hAB, 2'd2);
        vec[9]  = mk(4'h4, 1'b1, DC, 4'b0100, 1'b1, 32'hCD, 2'd2);
        vec[10] = mk(4'hA, 1'b1, D0, 4'b1000, 1'b1, 32'h13, 2'd3);
        vec[11] = mk(4'hA, 1'b1, D0, 4'b0010, 1'b1, 32'h11, 2'd1);
        vec[12] = mk(4'h0, 1'b1, D0, 4'b0000, 1'b0, 32'h11, 2'd1);
        vec[13] = mk(4'h0, 1'b0, D0, 4'b0000, 1'b0, 32'h11, 2'd1);

        #2 rst = 1'b0;
        s_wvalid = 4'hF;
        s_wdata = D0;
        chan_wready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("reset c%0d s_wready", c), 64'(s_wready), 64'h0);
            check_regs($sformatf("reset c%0d", c), 1'b0, 32'h0, 2'd0);
        end
        @(negedge clk) rst = 1'b1;

        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            s_wvalid = vec[k].v;
            chan_wready = vec[k].r;
            s_wdata = vec[k].d;
            #1 check($sformatf("v%0d s_wready", k), 64'(s_wready), 64'(vec[k].sr));
            @(posedge clk); #1;
            check_regs($sformatf("v%0d", k), vec[k].ev, vec[k].ed, vec[k].eg);
        end

        @(negedge clk);
        s_wvalid = 4'b0010;
        chan_wready = 1'b0;
        s_wdata = D0;
        #1 check("pre-reset load s_wready", 64'(s_wready), 64'b0010);
        @(posedge clk); #1;
        check_regs("pre-reset load", 1'b1, 32'h11, 2'd1);
        s_wvalid = 4'b1010;
        #2 rst = 1'b0;
        #1;
        check("async reset s_wready", 64'(s_wready), 64'h0);
        check_regs("async reset", 1'b0, 32'h0, 2'd0);
        @(negedge clk) rst = 1'b1;
        #1 check("post-reset s_wready", 64'(s_wready), 64'b0010);
        @(posedge clk); #1;
        check_regs("post-reset grant", 1'b1, 32'h11, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mygo_chan_arb.md
# mygo_chan_arb

Fan-in arbiter that lets several compiled process modules send on one Go channel by sharing the single write port of a `mygo_fifo_*` channel FIFO. It sits between N producer process instances and the FIFO's `in_*` port inside the generated top-level module. Senders are chosen round-robin, and each accepted word is latched into a one-entry output register. Senders block exactly as Go senders do until their word is taken.

## Interface
Parameters:
- N_SENDERS, 4, number of sending processes (2..16)
- WIDTH, 32, channel element width in bits
- IDW, $clog2(N_SENDERS), width of the sender index

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- s_wdata  in  N_SENDERS*WIDTH  sender i data at bits [i*WIDTH +: WIDTH]
- s_wvalid  in  N_SENDERS  sender i offers a word
- s_wready  out  N_SENDERS  sender i's word is accepted this cycle; at most one bit high
- chan_wdata  out  WIDTH  to FIFO in_data
- chan_wvalid  out  1  to FIFO in_valid
- chan_wready  in  1  from FIFO in_ready
- grant_id  out  IDW  index of the sender whose word is in the output register
- busy  out  1  output register holds a word (same as chan_wvalid)

## Operation
- State: `full` (output register occupied), `data_q[WIDTH]`, `grant_q[IDW]`, round-robin pointer `ptr_q[IDW]`.
- Reset values: full=0, data_q=0, grant_q=0, ptr_q=0. Resulting outputs: chan_wvalid=0, chan_wdata=0, grant_id=0, busy=0, s_wready=0.
- Two states:
  - EMPTY (full=0).
  - FULL (full=1).
- can_load = !full | chan_wready.
- Pick g is the first i with s_wvalid[i]=1, searching ptr_q, ptr_q+1, … mod N_SENDERS.
- s_wready[g] = can_load & |s_wvalid. All other s_wready bits are 0.
- On accept (can_load & |s_wvalid), on the clock edge:
  - data_q ← s_wdata[g]
  - grant_q ← g
  - full ← 1
  - ptr_q ← (g+1) mod N_SENDERS
- If there is no accept and chan_wready=1 while FULL, then full ← 0. data_q and grant_q hold their values.
- If there is no accept and no drain, all state holds.
- chan_wvalid = full, chan_wdata = data_q, grant_id = grant_q.
- Pointer wrap-around: after granting sender N_SENDERS-1, ptr_q returns to 0. With N_SENDERS not a power of 2, this is an explicit compare, not natural overflow.
- A sender that deasserts s_wvalid before it is granted is simply skipped. There is no residual lock.
- Reset mid-operation: the word in the output register is discarded and ptr_q returns to 0. Senders must re-offer their words.

## Timing
- Word accepted at edge t appears on chan_wvalid/chan_wdata after edge t, i.e. in cycle t+1.
- Throughput: 1 word/cycle when chan_wready=1 continuously. Simultaneous drain and load in FULL keeps full=1 with the new data.
- Combinational paths:
  - s_wvalid → s_wready
  - chan_wready → s_wready
- There is no combinational path from any input to chan_wvalid/chan_wdata/grant_id.
- Fairness: with all senders continuously valid and chan_wready=1, each sender is granted once every N_SENDERS cycles.

## Structure
- Package `mygo_chan_pkg` holds the shared channel handshake typedef, the IDW computation function, and the reset-polarity constant used by all channel blocks.
- One sub-module, `mygo_rr_pick`. It is combinational: valid vector + pointer → one-hot grant + index. It is reusable for future select-statement arbitration.
- `mygo_chan_arb` owns only the output register, the pointer and the handshake logic.

## Test plan
- Reset, then hold rst=0 for 3 cycles with all s_wvalid=1. Required: all s_wready=0, chan_wvalid=0, grant_id=0.
- N=4, all senders valid with data 0x10..0x13, chan_wready=1. Required:
  - chan_wdata sequence 0x10,0x11,0x12,0x13,0x10 on consecutive cycles.
  - Each s_wready pulses exactly once per 4 cycles.
- Sender 2 only valid (0xAB), chan_wready=0. Required:
  - Accepted once, after which chan_wvalid=1, grant_id=2 and s_wready=0 while stalled.
  - Raising chan_wready for one cycle drains 0xAB and loads the next word in the same cycle.
- Senders 1 and 3 valid, ptr at 3. Required: sender 3 granted first, ptr wraps to 0, then sender 1 granted.
- Assert rst while full=1 and chan_wready=0. Required: chan_wvalid drops immediately (asynchronously), and the first grant after release goes to the lowest valid index.
